// File: rtl/complex_mult_pipe.sv
// complex_mult_pipe: pipelined complex multiply with valid/ready, conj(B), round-half-up rescale, ovf.
// Build option: define COMPLEX_MULT_SAT_EN to clamp out-of-range results instead of wrapping.
module complex_mult_pipe #(
    parameter int DATA_W  = 16,
    parameter int OUT_W   = 16,
    parameter int SHIFT   = 15,
    parameter int LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DATA_W-1:0]   a_in,
    input  logic [2*DATA_W-1:0]   b_in,
    input  logic                  conj_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*OUT_W-1:0]    y_out,
    output logic                  ovf
);

    // full-precision width, one guard bit for the rounding add
    localparam int FW = 2*DATA_W + 2;
    localparam int RW = FW + 1;
    // result-register chain after the product stage
    localparam int CH = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam logic [RW-1:0] ONE = RW'(1);
    localparam logic signed [RW-1:0] RND = (ONE << SHIFT) >> 1;
    localparam logic [OUT_W-1:0] O_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] O_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    if (DATA_W < 2 || DATA_W > 32) begin : g_bad_dw
        $error("DATA_W out of range");
    end
    if (OUT_W < 2 || OUT_W > 2*DATA_W + 1) begin : g_bad_ow
        $error("OUT_W out of range");
    end
    if (SHIFT < 0 || SHIFT > 2*DATA_W) begin : g_bad_sh
        $error("SHIFT out of range");
    end
    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_lat
        $error("LATENCY out of range");
    end

    logic en;
    logic signed [FW-1:0] a_re, a_im, b_re, b_im, bi;
    logic signed [FW-1:0] m_rr, m_ii, m_ri, m_ir;
    logic signed [FW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic                 p_v;
    logic signed [RW-1:0] re_full, im_full, re_r, im_r;
    logic [RW-OUT_W:0]    re_top, im_top;
    logic                 re_o, im_o;
    logic [OUT_W-1:0]     y_re, y_im;
    logic [2*OUT_W-1:0]   s_y;
    logic                 s_ovf;
    logic [CH-1:0]        v_q;
    logic [2*OUT_W-1:0]   y_q [CH];
    logic                 o_q [CH];

    // global advance: every stage moves unless a result is waiting
    assign en       = !out_valid || out_ready;
    assign in_ready = en && !rst;

    // sign-extend operands; conj negation widened so -MIN cannot wrap
    always_comb begin
        a_re = {{(FW-DATA_W){a_in[2*DATA_W-1]}}, a_in[2*DATA_W-1:DATA_W]};
        a_im = {{(FW-DATA_W){a_in[DATA_W-1]}}, a_in[DATA_W-1:0]};
        b_re = {{(FW-DATA_W){b_in[2*DATA_W-1]}}, b_in[2*DATA_W-1:DATA_W]};
        b_im = {{(FW-DATA_W){b_in[DATA_W-1]}}, b_in[DATA_W-1:0]};
        bi   = conj_b ? -b_im : b_im;
        m_rr = a_re * b_re;
        m_ii = a_im * bi;
        m_ri = a_re * bi;
        m_ir = a_im * b_re;
    end

    if (LATENCY > 1) begin : g_prod
        // product stage valid bit
        always_ff @(posedge clk) begin
            if (rst) begin
                p_v <= 1'b0;
            end else if (en) begin
                p_v <= in_valid;
            end
        end

        // product registers load only with a real sample
        always_ff @(posedge clk) begin
            if (en && in_valid && in_ready) begin
                p_rr <= m_rr;
                p_ii <= m_ii;
                p_ri <= m_ri;
                p_ir <= m_ir;
            end
        end
    end else begin : g_noprod
        // single-stage build: products feed the output register directly
        always_comb begin
            p_v  = in_valid && in_ready;
            p_rr = m_rr;
            p_ii = m_ii;
            p_ri = m_ri;
            p_ir = m_ir;
        end
    end

    // sum, round half up, rescale, range check and narrow
    always_comb begin
        re_full = {p_rr[FW-1], p_rr} - {p_ii[FW-1], p_ii};
        im_full = {p_ri[FW-1], p_ri} + {p_ir[FW-1], p_ir};
        re_r    = (re_full + RND) >>> SHIFT;
        im_r    = (im_full + RND) >>> SHIFT;
        re_top  = re_r[RW-1:OUT_W-1];
        im_top  = im_r[RW-1:OUT_W-1];
        re_o    = !((&re_top) || !(|re_top));
        im_o    = !((&im_top) || !(|im_top));
        s_ovf   = re_o || im_o;
`ifdef COMPLEX_MULT_SAT_EN
        y_re = re_o ? (re_r[RW-1] ? O_MIN : O_MAX) : re_r[OUT_W-1:0];
        y_im = im_o ? (im_r[RW-1] ? O_MIN : O_MAX) : im_r[OUT_W-1:0];
`else
        y_re = re_r[OUT_W-1:0];
        y_im = im_r[OUT_W-1:0];
`endif
        s_y = {y_re, y_im};
    end

    // result chain; last entry is the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < CH; i++) begin
                y_q[i] <= '0;
                o_q[i] <= 1'b0;
            end
        end else if (en) begin
            v_q[0] <= p_v;
            if (p_v) begin
                y_q[0] <= s_y;
                o_q[0] <= s_ovf;
            end
            for (int i = 1; i < CH; i++) begin
                v_q[i] <= v_q[i-1];
                if (v_q[i-1]) begin
                    y_q[i] <= y_q[i-1];
                    o_q[i] <= o_q[i-1];
                end
            end
        end
    end

    assign out_valid = v_q[CH-1];
    assign y_out     = y_q[CH-1];
    assign ovf       = o_q[CH-1];

    // both limits are only referenced by the clamping build
    logic unused_lim;
    assign unused_lim = ^{O_MAX, O_MIN};

endmodule

// File: tb/tb_complex_mult_pipe.sv
// tb_complex_mult_pipe: random + directed checks of complex_mult_pipe against a behavioural model.
// Two instances: default parameters and DATA_W=8/OUT_W=17/SHIFT=0/LATENCY=1.
module tb_complex_mult_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic iv0, rdy0, cj0, ov0, or0, ovf0;
    logic [31:0] a0, b0, y0;
    logic iv1, rdy1, cj1, ov1, or1, ovf1;
    logic [15:0] a1, b1;
    logic [33:0] y1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [64:0] q0[$];
    logic [64:0] q1[$];

    complex_mult_pipe d0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(rdy0),
        .a_in(a0), .b_in(b0), .conj_b(cj0), .out_valid(ov0),
        .out_ready(or0), .y_out(y0), .ovf(ovf0)
    );

    complex_mult_pipe #(.DATA_W(8), .OUT_W(17), .SHIFT(0), .LATENCY(1)) d1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1),
        .a_in(a1), .b_in(b1), .conj_b(cj1), .out_valid(ov1),
        .out_ready(or1), .y_out(y1), .ovf(ovf1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic longint sx(input logic [63:0] v, input int w);
        longint x = longint'(v) & ((longint'(1) << w) - 1);
        if (v[w-1]) x = x - (longint'(1) << w);
        return x;
    endfunction

    // reference: plain integer complex product, rescale, range, narrow
    function automatic logic [64:0] model(input int dw, input int ow, input int sh,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic cj);
        longint ar = sx(a >> dw, dw);
        longint ai = sx(a, dw);
        longint br = sx(b >> dw, dw);
        longint bi = sx(b, dw);
        longint re, im, lo, hi;
        logic o;
        logic [63:0] yr, yi, mk;
        if (cj) bi = -bi;
        re = ar * br - ai * bi;
        im = ar * bi + ai * br;
        if (sh > 0) begin
            re = (re + (longint'(1) << (sh - 1))) >>> sh;
            im = (im + (longint'(1) << (sh - 1))) >>> sh;
        end
        lo = -(longint'(1) << (ow - 1));
        hi = (longint'(1) << (ow - 1)) - 1;
        o = (re < lo) || (re > hi) || (im < lo) || (im > hi);
`ifdef COMPLEX_MULT_SAT_EN
        if (re > hi) re = hi;
        if (re < lo) re = lo;
        if (im > hi) im = hi;
        if (im < lo) im = lo;
`endif
        mk = (64'd1 << ow) - 1;
        yr = 64'(re) & mk;
        yi = 64'(im) & mk;
        return {o, (yr << ow) | yi};
    endfunction

    // scoreboard for d0, sampled just before each rising edge
    always begin
        logic [64:0] e;
        @(negedge clk);
        #4;
        chk("rdy0", rdy0, 64'((!ov0 || or0) && !rst));
        if (rst) begin
            q0.delete();
        end else begin
            if (ov0 && or0) begin
                n_cmp++;
                if (q0.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra0: got result %h want none", y0);
                end else begin
                    e = q0.pop_front();
                    chk("y0", y0, e[31:0]);
                    chk("ovf0", ovf0, e[64]);
                end
            end else if (ov0 && q0.size() > 0) begin
                chk("hold_y0", y0, q0[0][31:0]);
                chk("hold_ovf0", ovf0, q0[0][64]);
            end
            if (iv0 && rdy0) q0.push_back(model(16, 16, 15, {32'b0, a0}, {32'b0, b0}, cj0));
        end
    end

    // scoreboard for d1
    always begin
        logic [64:0] e;
        @(negedge clk);
        #4;
        chk("rdy1", rdy1, 64'((!ov1 || or1) && !rst));
        if (rst) begin
            q1.delete();
        end else begin
            if (ov1) chk("ovf1_never", ovf1, 0);
            if (ov1 && or1) begin
                n_cmp++;
                if (q1.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra1: got result %h want none", y1);
                end else begin
                    e = q1.pop_front();
                    chk("y1", y1, e[33:0]);
                    chk("ovf1", ovf1, e[64]);
                end
            end else if (ov1 && q1.size() > 0) begin
                chk("hold_y1", y1, q1[0][33:0]);
            end
            if (iv1 && rdy1) q1.push_back(model(8, 17, 0, {48'b0, a1}, {48'b0, b1}, cj1));
        end
    end

    function automatic logic [15:0] r16();
        return ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
    endfunction

    function automatic logic [7:0] r8();
        return ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
    endfunction

    // one sample into an idle d0; latency and literal result
    task automatic single(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic cj, input logic [31:0] ey, input logic eo);
        logic [64:0] m;
        int n = 0;
        m = model(16, 16, 15, {32'b0, a}, {32'b0, b}, cj);
        chk({nm, "_model_y"}, m[31:0], ey);
        chk({nm, "_model_ovf"}, m[64], eo);
        @(negedge clk);
        a0 = a; b0 = b; cj0 = cj; iv0 = 1'b1; or0 = 1'b1;
        @(negedge clk);
        iv0 = 1'b0;
        while (!ov0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_lat"}, n, 2);
        chk({nm, "_y"}, y0, ey);
        chk({nm, "_ovf"}, ovf0, eo);
        @(negedge clk);
    endtask

    task automatic backpressure();
        int k = 0;
        int cyc = 0;
        logic acc;
        @(negedge clk);
        iv0 = 1'b1; a0 = {r16(), r16()}; b0 = {r16(), r16()}; cj0 = 1'($urandom);
        while (k < 10 && cyc < 200) begin
            or0 = (cyc % 3 == 0);
            #4;
            acc = rdy0;
            @(negedge clk);
            cyc++;
            if (acc) begin
                k++;
                a0 = {r16(), r16()}; b0 = {r16(), r16()}; cj0 = 1'($urandom);
            end
        end
        iv0 = 1'b0;
        chk("bp_accepted", k, 10);
        or0 = 1'b1;
        repeat (6) @(negedge clk);
        chk("bp_drain", q0.size(), 0);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        or0 = 1'b0; iv0 = 1'b1;
        repeat (3) begin
            a0 = {r16(), r16()}; b0 = {r16(), r16()}; cj0 = 1'($urandom);
            @(negedge clk);
        end
        iv0 = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rm_ov", ov0, 0);
        chk("rm_y", y0, 0);
        or0 = 1'b1;
        single("after_rst", {16'h4000, 16'h0000}, {16'h4000, 16'h4000}, 1'b1,
               {16'h2000, 16'hE000}, 1'b0);
        repeat (4) @(negedge clk);
        chk("rm_gone", q0.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        iv0 = 1'b0; or0 = 1'b1; cj0 = 1'b0; a0 = '0; b0 = '0;
        iv1 = 1'b0; or1 = 1'b1; cj1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        #4;
        chk("rst_rdy0", rdy0, 0);
        chk("rst_rdy1", rdy1, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ov0", ov0, 0);
        chk("rst_y0", y0, 0);
        chk("rst_ovf0", ovf0, 0);
        chk("rst_ov1", ov1, 0);
        chk("rst_y1", y1, 0);

        single("half", {16'h4000, 16'h0000}, {16'h4000, 16'h4000}, 1'b0,
               {16'h2000, 16'h2000}, 1'b0);
        single("conj", {16'h4000, 16'h0000}, {16'h4000, 16'h4000}, 1'b1,
               {16'h2000, 16'hE000}, 1'b0);
`ifdef COMPLEX_MULT_SAT_EN
        single("ovf", {16'h8000, 16'h0000}, {16'h8000, 16'h0000}, 1'b0,
               {16'h7FFF, 16'h0000}, 1'b1);
`else
        single("ovf", {16'h8000, 16'h0000}, {16'h8000, 16'h0000}, 1'b0,
               {16'h8000, 16'h0000}, 1'b1);
`endif
        single("rnd_up", {16'h0001, 16'h0000}, {16'h4000, 16'h0000}, 1'b0,
               {16'h0001, 16'h0000}, 1'b0);
        single("rnd_dn", {16'h0001, 16'h0000}, {16'h3FFF, 16'h0000}, 1'b0,
               {16'h0000, 16'h0000}, 1'b0);

        backpressure();
        reset_mid();

        fork
            begin
                repeat (300) begin
                    @(negedge clk);
                    iv0 = ($urandom_range(0, 9) < 7);
                    or0 = ($urandom_range(0, 9) < 7);
                    cj0 = 1'($urandom);
                    a0 = {r16(), r16()};
                    b0 = {r16(), r16()};
                end
            end
            begin
                repeat (300) begin
                    @(negedge clk);
                    iv1 = ($urandom_range(0, 9) < 7);
                    or1 = ($urandom_range(0, 9) < 7);
                    cj1 = 1'($urandom);
                    a1 = {r8(), r8()};
                    b1 = {r8(), r8()};
                end
            end
        join
        @(negedge clk);
        iv0 = 1'b0; or0 = 1'b1;
        iv1 = 1'b0; or1 = 1'b1;
        repeat (8) @(negedge clk);
        chk("drain0", q0.size(), 0);
        chk("drain1", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
